// File: rtl/csi2tx_n_lane_ldl_pkg.sv
// Shared definitions for the CSI-2 TX lane distribution layer: state encoding,
// short-packet size and lane-count legality helpers.
package csi2tx_n_lane_ldl_pkg;

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    RD_HDR     = 3'd1,
    DLY        = 3'd2,
    XFER       = 3'd3,
    STOP_STATE = 3'd4,
    HS_EXIT    = 3'd5
  } ldl_state_e;

  localparam int CSI2TX_SP_BYTES = 4;

  // Bit n set means a lane count of n is a legal encoding (1, 2, 4, 8).
  localparam logic [15:0] CSI2TX_LANE_MASK = 16'h0116;

  function automatic logic lane_cnt_legal(input logic [3:0] cnt, input int num_lanes);
    return CSI2TX_LANE_MASK[cnt] && (int'(cnt) <= num_lanes);
  endfunction

  // Index of the last byte slice of a FIFO word for a given lane count.
  function automatic logic [2:0] slice_max(input logic [3:0] lanes);
    case (lanes)
      4'd1:    return 3'd7;
      4'd2:    return 3'd3;
      4'd4:    return 3'd1;
      default: return 3'd0;
    endcase
  endfunction

endpackage

// File: rtl/csi2tx_n_lane_ldl_if.sv
// FIFO-side and PPI-side signal bundle of the lane distribution layer.
interface csi2tx_n_lane_ldl_if #(
  parameter int NUM_LANES = 8,
  parameter int FIFO_DW   = 64,
  parameter int BC_W      = 17
);
  logic                     csi_byte_fifo_empty;
  logic                     short_packet;
  logic [BC_W-1:0]          packet_byte_cnt;
  logic [FIFO_DW-1:0]       fifo_rd_data;
  logic                     fifo_rd_en;
  logic                     header_info;
  logic [8*NUM_LANES-1:0]   txdatahs;
  logic [NUM_LANES-1:0]     txrequesths;
  logic [NUM_LANES-1:0]     txreadyhs;

  modport master (
    input  csi_byte_fifo_empty, short_packet, packet_byte_cnt, fifo_rd_data, txreadyhs,
    output fifo_rd_en, header_info, txdatahs, txrequesths
  );

  modport slave (
    output csi_byte_fifo_empty, short_packet, packet_byte_cnt, fifo_rd_data, txreadyhs,
    input  fifo_rd_en, header_info, txdatahs, txrequesths
  );
endinterface

// File: rtl/csi2tx_n_lane_ldl_byte_mux.sv
// Combinational selector: routes byte (slice*lanes + k) of the current FIFO word
// onto lane k; unrequested or inactive lanes drive zero.
module csi2tx_ldl_byte_mux #(
  parameter int NUM_LANES = 8,
  parameter int FIFO_DW   = 64
) (
  input  logic [FIFO_DW-1:0]     word,
  input  logic [2:0]             slice,
  input  logic [3:0]             lanes,
  input  logic [NUM_LANES-1:0]   lane_en,
  output logic [8*NUM_LANES-1:0] data
);

  logic [2:0] sel [NUM_LANES];

  // NOTE: every output gets a default before the loop so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    data = '0;
    for (int k = 0; k < NUM_LANES; k++) begin
      sel[k] = 3'(int'(slice) * int'(lanes) + k);
      if (lane_en[k] && (k < int'(lanes))) begin
        data[8*k +: 8] = word[8*sel[k] +: 8];
      end
    end
  end

endmodule

// File: rtl/csi2tx_n_lane_ldl.sv
// Lane distribution layer: reads a packet header word, spreads packet bytes
// round-robin over the active PPI lanes, then sequences stop state and HS exit.
module csi2tx_n_lane_ldl
  import csi2tx_n_lane_ldl_pkg::*;
#(
  parameter int NUM_LANES = 8,
  parameter int FIFO_DW   = 64,
  parameter int BC_W      = 17
) (
  input  logic               txbyteclkhs,
  input  logic               txbyteclkhs_rst_n,
  input  logic               tinit_start,
  input  logic [3:0]         lane_cnt,
  input  logic               enable_hs_transmission,
  input  logic               forcetxstopmode,
  input  logic               stop_state_dl,
  input  logic               hs_exit_cnt_expired,
  csi2tx_n_lane_ldl_if.master bus,
  output logic               tx_done,
  output logic               hs_exit_cnt_decr_enable,
  output logic               lane_cfg_err
);

  ldl_state_e           state_q, state_d;
  logic [3:0]           lanes_q, lanes_d;
  logic [BC_W-1:0]      rem_q, rem_d;
  logic [2:0]           slice_q, slice_d;

  logic                 abort;
  logic                 legal;
  logic [NUM_LANES-1:0] req;
  logic                 beat;
  logic                 last_beat;
  logic                 slice_wrap;
  logic [BC_W-1:0]      lanes_ext;
  logic [BC_W-1:0]      take;
  logic                 rd_en;
  logic                 unused_ready;

  // Only lane 0's ready acts as the beat strobe; the other bits are ignored.
  assign unused_ready = ^bus.txreadyhs;

  assign abort      = forcetxstopmode | ~tinit_start;
  assign legal      = lane_cnt_legal(lane_cnt, NUM_LANES);
  assign lanes_ext  = BC_W'(lanes_q);
  assign take       = (rem_q < lanes_ext) ? rem_q : lanes_ext;
  assign slice_wrap = (slice_q == slice_max(lanes_q));

  always_comb begin
    req = '0;
    for (int k = 0; k < NUM_LANES; k++) begin
      req[k] = (state_q == XFER) && (k < int'(lanes_q)) && (rem_q > BC_W'(k)) && !abort;
    end
  end

  assign beat      = req[0] & bus.txreadyhs[0];
  assign last_beat = beat && (rem_q <= lanes_ext);

  always_comb begin
    state_d = state_q;
    lanes_d = lanes_q;
    rem_d   = rem_q;
    slice_d = slice_q;
    rd_en   = 1'b0;
    case (state_q)
      IDLE: begin
        if (enable_hs_transmission && !bus.csi_byte_fifo_empty && legal) begin
          state_d = RD_HDR;
          lanes_d = lane_cnt;
        end
      end
      RD_HDR: begin
        rd_en   = 1'b1;
        state_d = DLY;
      end
      DLY: begin
        // A zero long-packet count is treated as a bare header.
        rem_d   = (bus.short_packet || (bus.packet_byte_cnt == '0))
                  ? BC_W'(CSI2TX_SP_BYTES) : bus.packet_byte_cnt;
        slice_d = '0;
        state_d = XFER;
      end
      XFER: begin
        if (beat) begin
          rem_d   = rem_q - take;
          slice_d = slice_wrap ? 3'd0 : slice_q + 3'd1;
          if (last_beat) state_d = STOP_STATE;
          else if (slice_wrap) rd_en = 1'b1;
        end
      end
      STOP_STATE: if (stop_state_dl)       state_d = HS_EXIT;
      HS_EXIT:    if (hs_exit_cnt_expired) state_d = IDLE;
      default:    state_d = IDLE;
    endcase
    if (abort) begin
      state_d = IDLE;
      rem_d   = '0;
      slice_d = '0;
      rd_en   = 1'b0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge txbyteclkhs or negedge txbyteclkhs_rst_n) begin
    if (!txbyteclkhs_rst_n) begin
      state_q <= IDLE;
      lanes_q <= '0;
      rem_q   <= '0;
      slice_q <= '0;
    end else begin
      state_q <= state_d;
      lanes_q <= lanes_d;
      rem_q   <= rem_d;
      slice_q <= slice_d;
    end
  end

  csi2tx_ldl_byte_mux #(
    .NUM_LANES (NUM_LANES),
    .FIFO_DW   (FIFO_DW)
  ) u_byte_mux (
    .word    (bus.fifo_rd_data),
    .slice   (slice_q),
    .lanes   (lanes_q),
    .lane_en (req),
    .data    (bus.txdatahs)
  );

  assign bus.txrequesths       = req;
  assign bus.fifo_rd_en        = rd_en;
  assign bus.header_info       = (state_q == DLY);
  assign tx_done               = (state_q == STOP_STATE);
  assign hs_exit_cnt_decr_enable = (state_q == HS_EXIT);
  assign lane_cfg_err          = (state_q == IDLE) && !legal;

endmodule

// File: tb/tb_csi2tx_n_lane_ldl.sv
// Self-checking bench: random packets checked against a byte-stream model of
// round-robin lane distribution, plus directed abort and lane-config cases.
module tb_csi2tx_n_lane_ldl;

  logic       clk;
  logic       rst_n;
  logic       tinit_start;
  logic [3:0] lane_cnt;
  logic       enable;
  logic       force_stop;
  logic       stop_state_dl;
  logic       hs_expired;
  logic       tx_done;
  logic       hs_dec;
  logic       cfg_err;

  logic [3:0] lane_cnt4;
  logic       tx_done4, hs_dec4, cfg_err4;

  csi2tx_n_lane_ldl_if #(.NUM_LANES(8), .FIFO_DW(64), .BC_W(17)) bus ();
  csi2tx_n_lane_ldl_if #(.NUM_LANES(4), .FIFO_DW(64), .BC_W(17)) bus4 ();

  csi2tx_n_lane_ldl #(.NUM_LANES(8), .FIFO_DW(64), .BC_W(17)) dut (
    .txbyteclkhs             (clk),
    .txbyteclkhs_rst_n       (rst_n),
    .tinit_start             (tinit_start),
    .lane_cnt                (lane_cnt),
    .enable_hs_transmission  (enable),
    .forcetxstopmode         (force_stop),
    .stop_state_dl           (stop_state_dl),
    .hs_exit_cnt_expired     (hs_expired),
    .bus                     (bus),
    .tx_done                 (tx_done),
    .hs_exit_cnt_decr_enable (hs_dec),
    .lane_cfg_err            (cfg_err)
  );

  csi2tx_n_lane_ldl #(.NUM_LANES(4), .FIFO_DW(64), .BC_W(17)) dut4 (
    .txbyteclkhs             (clk),
    .txbyteclkhs_rst_n       (rst_n),
    .tinit_start             (1'b1),
    .lane_cnt                (lane_cnt4),
    .enable_hs_transmission  (1'b0),
    .forcetxstopmode         (1'b0),
    .stop_state_dl           (1'b0),
    .hs_exit_cnt_expired     (1'b0),
    .bus                     (bus4),
    .tx_done                 (tx_done4),
    .hs_exit_cnt_decr_enable (hs_dec4),
    .lane_cfg_err            (cfg_err4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // FIFO model: words appear on the read port one cycle after the strobe.
  logic [63:0] fifo_q [$];
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) bus.fifo_rd_data <= '0;
    else if (bus.fifo_rd_en) bus.fifo_rd_data <= (fifo_q.size() > 0) ? fifo_q.pop_front() : 64'h0;
  end

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference packet state
  logic [7:0] pkt [$];
  int n_bytes;
  int pos, beats, reads;

  task automatic start_packet(input int l, input bit sp, input int pbc);
    int nw;
    logic [63:0] w;
    n_bytes = sp ? 4 : ((pbc == 0) ? 4 : pbc);
    pkt.delete();
    for (int i = 0; i < n_bytes; i++) pkt.push_back(8'($urandom));
    nw = (n_bytes + 7) / 8;
    for (int wi = 0; wi < nw; wi++) begin
      for (int b = 0; b < 8; b++)
        w[8*b +: 8] = (8*wi + b < n_bytes) ? pkt[8*wi + b] : 8'($urandom);
      fifo_q.push_back(w);
    end
    @(negedge clk);
    lane_cnt = 4'(l);
    bus.short_packet = sp;
    bus.packet_byte_cnt = 17'(pbc);
    bus.csi_byte_fifo_empty = 1'b0;
    enable = 1'b1;
    #1;
    check("start_cfg_err", 64'(cfg_err), 64'h0);
    check("start_req", 64'(bus.txrequesths), 64'h0);
    @(negedge clk);
    bus.csi_byte_fifo_empty = 1'b1;
    enable = 1'b0;
    #1;
    check("hdr_rd_en", 64'(bus.fifo_rd_en), 64'h1);
    check("hdr_info_early", 64'(bus.header_info), 64'h0);
    @(negedge clk);
    #1;
    check("dly_header_info", 64'(bus.header_info), 64'h1);
    check("dly_rd_en", 64'(bus.fifo_rd_en), 64'h0);
    check("dly_req", 64'(bus.txrequesths), 64'h0);
    @(negedge clk);
  endtask

  // rmode: 0 ready tied high, 1 ready pattern 1,0,0,1, 2 random ready
  task automatic xfer(input int l, input int rmode, input int max_beats);
    logic [3:0]  pat;
    logic        ready;
    logic [7:0]  exp_req;
    logic [63:0] exp_data;
    logic        exp_rd;
    int          cnt, cyc, budget;
    pat = 4'b1001;
    pos = 0; beats = 0; reads = 0; cyc = 0;
    budget = 8 * n_bytes + 40;
    while (pos < n_bytes && beats < max_beats && cyc < budget) begin
      case (rmode)
        0:       ready = 1'b1;
        1:       ready = pat[cyc % 4];
        default: ready = 1'($urandom_range(0, 1));
      endcase
      bus.txreadyhs = 8'($urandom);
      bus.txreadyhs[0] = ready;
      lane_cnt = 4'($urandom);
      #1;
      cnt = (n_bytes - pos < l) ? n_bytes - pos : l;
      exp_req = '0;
      exp_data = '0;
      for (int k = 0; k < cnt; k++) begin
        exp_req[k] = 1'b1;
        exp_data[8*k +: 8] = pkt[pos + k];
      end
      exp_rd = ready && ((pos + l) % 8 == 0) && (pos + l < n_bytes);
      check($sformatf("req@%0d", pos), 64'(bus.txrequesths), 64'(exp_req));
      check($sformatf("data@%0d", pos), bus.txdatahs, exp_data);
      check($sformatf("rd_en@%0d", pos), 64'(bus.fifo_rd_en), 64'(exp_rd));
      if (bus.fifo_rd_en) reads++;
      @(posedge clk);
      if (ready) begin
        pos += l;
        beats++;
      end
      cyc++;
      @(negedge clk);
    end
    if (beats < max_beats) check("xfer_all_bytes_sent", 64'(pos >= n_bytes), 64'h1);
  endtask

  task automatic finish_packet(input int l);
    #1;
    check("stop_tx_done", 64'(tx_done), 64'h1);
    check("stop_req", 64'(bus.txrequesths), 64'h0);
    check("stop_data", bus.txdatahs, 64'h0);
    check("stop_rd_en", 64'(bus.fifo_rd_en), 64'h0);
    check("beat_count", 64'(beats), 64'((n_bytes + l - 1) / l));
    check("word_reads", 64'(reads), 64'((n_bytes + 7) / 8 - 1));
    @(negedge clk);
    #1;
    check("stop_hold", 64'(tx_done), 64'h1);
    stop_state_dl = 1'b1;
    @(negedge clk);
    stop_state_dl = 1'b0;
    #1;
    check("hs_exit_en", 64'(hs_dec), 64'h1);
    check("hs_exit_tx_done", 64'(tx_done), 64'h0);
    hs_expired = 1'b1;
    @(negedge clk);
    hs_expired = 1'b0;
    #1;
    check("idle_hs_exit", 64'(hs_dec), 64'h0);
    check("idle_state", 64'(dut.state_q), 64'h0);
    check("fifo_drained", 64'(fifo_q.size()), 64'h0);
  endtask

  task automatic run_packet(input int l, input bit sp, input int pbc, input int rmode);
    start_packet(l, sp, pbc);
    xfer(l, rmode, 1 << 20);
    finish_packet(l);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int l;
    logic [3:0] vals [9];
    rst_n = 1'b0;
    tinit_start = 1'b1;
    lane_cnt = 4'd1;
    lane_cnt4 = 4'd1;
    enable = 1'b0;
    force_stop = 1'b0;
    stop_state_dl = 1'b0;
    hs_expired = 1'b0;
    bus.csi_byte_fifo_empty = 1'b1;
    bus.short_packet = 1'b0;
    bus.packet_byte_cnt = '0;
    bus.txreadyhs = '0;
    bus4.csi_byte_fifo_empty = 1'b1;
    bus4.short_packet = 1'b0;
    bus4.packet_byte_cnt = '0;
    bus4.fifo_rd_data = '0;
    bus4.txreadyhs = '0;
    #2;
    check("rst_rd_en", 64'(bus.fifo_rd_en), 64'h0);
    check("rst_req", 64'(bus.txrequesths), 64'h0);
    check("rst_data", bus.txdatahs, 64'h0);
    check("rst_header_info", 64'(bus.header_info), 64'h0);
    check("rst_tx_done", 64'(tx_done), 64'h0);
    check("rst_hs_exit", 64'(hs_dec), 64'h0);
    check("rst_cfg_err", 64'(cfg_err), 64'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Lane count legality in IDLE (no start: enable low)
    vals = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd8, 4'd9, 4'd15};
    foreach (vals[i]) begin
      @(negedge clk);
      lane_cnt = vals[i];
      #1;
      check($sformatf("cfg_err_lc%0d", vals[i]), 64'(cfg_err),
            64'(!(vals[i] == 1 || vals[i] == 2 || vals[i] == 4 || vals[i] == 8)));
    end
    lane_cnt4 = 4'd8;
    #1 check("cfg_err_nl4_lc8", 64'(cfg_err4), 64'h1);
    lane_cnt4 = 4'd4;
    #1 check("cfg_err_nl4_lc4", 64'(cfg_err4), 64'h0);

    run_packet(2, 1'b0, 20, 0);
    run_packet(4, 1'b0, 10, 0);
    run_packet(8, 1'b1, $urandom_range(1, 100), 0);
    run_packet(2, 1'b0, 24, 1);

    // Abort mid-transfer, then a clean restart from slice 0
    start_packet(1, 1'b0, 20);
    xfer(1, 0, 5);
    force_stop = 1'b1;
    bus.txreadyhs = '1;
    #1;
    check("force_req", 64'(bus.txrequesths), 64'h0);
    check("force_data", bus.txdatahs, 64'h0);
    check("force_rd_en", 64'(bus.fifo_rd_en), 64'h0);
    @(negedge clk);
    #1;
    check("force_idle", 64'(dut.state_q), 64'h0);
    check("force_tx_done", 64'(tx_done), 64'h0);
    force_stop = 1'b0;
    fifo_q.delete();
    run_packet(4, 1'b0, 12, 0);

    // Loss of init behaves like a forced stop
    start_packet(2, 1'b0, 16);
    xfer(2, 0, 2);
    tinit_start = 1'b0;
    #1 check("tinit_req", 64'(bus.txrequesths), 64'h0);
    @(negedge clk);
    #1 check("tinit_idle", 64'(dut.state_q), 64'h0);
    tinit_start = 1'b1;
    fifo_q.delete();

    // Illegal lane count holds IDLE with a non-empty FIFO
    @(negedge clk);
    lane_cnt = 4'd3;
    enable = 1'b1;
    bus.csi_byte_fifo_empty = 1'b0;
    for (int c = 0; c < 3; c++) begin
      #1;
      check("illegal_cfg_err", 64'(cfg_err), 64'h1);
      check("illegal_rd_en", 64'(bus.fifo_rd_en), 64'h0);
      check("illegal_idle", 64'(dut.state_q), 64'h0);
      @(negedge clk);
    end
    enable = 1'b0;
    bus.csi_byte_fifo_empty = 1'b1;
    run_packet(1, 1'b0, 10, 2);

    run_packet(2, 1'b0, 0, 2);
    repeat (8) begin
      l = 1 << $urandom_range(0, 3);
      run_packet(l, ($urandom_range(0, 3) == 0), $urandom_range(1, 40), 2);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
